// File: rtl/datapath.sv
// Execution datapath for the accumulator CPU: PC, IR, 4-entry register file, ACC, ALU, Z/C flags; optional debug tap via DATAPATH_DBG_EN.
// Latency: every load is visible one cycle after its edge; ALU is combinational ahead of the ACC/flag registers.
// Backpressure: none; the controller applies a control word every cycle and the datapath never stalls.
module datapath #(
    parameter int DW   = 8,
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            CLB,
    input  logic            LoadIR,
    input  logic            IncPC,
    input  logic            SelPC,
    input  logic            LoadPC,
    input  logic            LoadReg,
    input  logic            LoadAcc,
    input  logic [1:0]      SelACC,
    input  logic [3:0]      SelALU,
    input  logic [DW-1:0]   imem_data,
    output logic [PC_W-1:0] imem_addr,
    output logic [3:0]      op,
    output logic            z,
    output logic            c,
`ifdef DATAPATH_DBG_EN
    input  logic [1:0]      dbg_sel,
    output logic [DW-1:0]   dbg_reg,
    output logic [DW-1:0]   acc_out
`else
    output logic [DW-1:0]   acc_out
`endif
);

    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_NOR = 4'b0011;
    localparam logic [3:0] ALU_SHL = 4'b1011;
    localparam logic [3:0] ALU_SHR = 4'b1100;

    localparam logic [1:0] ACC_ALU  = 2'b00;
    localparam logic [1:0] ACC_REG  = 2'b01;
    localparam logic [1:0] ACC_IMM  = 2'b10;

    logic [PC_W-1:0] pc;
    logic [DW-1:0]   ir;
    logic [DW-1:0]   acc;
    logic [DW-1:0]   rf [4];
    logic            z_q;
    logic            c_q;

    logic [1:0]      rs;
    logic [DW-1:0]   rf_b;
    logic [DW-1:0]   imm;
    logic [PC_W-1:0] rel_tgt;
    logic [PC_W-1:0] reg_tgt;
    logic [DW:0]     alu_wide;
    logic [DW-1:0]   alu_res;
    logic            alu_c;

    // Register operand and immediate both come from the low IR nibble.
    assign rs      = ir[1:0];
    assign rf_b    = rf[rs];
    assign imm     = {{(DW-4){1'b0}}, ir[3:0]};
    assign rel_tgt = pc + {{(PC_W-4){ir[3]}}, ir[3:0]};

    // A register jump target narrower or wider than PC is truncated or zero-extended.
    if (PC_W <= DW) begin : g_tgt_trunc
        assign reg_tgt = rf_b[PC_W-1:0];
    end else begin : g_tgt_zext
        assign reg_tgt = {{(PC_W-DW){1'b0}}, rf_b};
    end

    // ALU: A = ACC, B = R[rs]; unlisted function codes pass A through with carry cleared.
    always_comb begin
        alu_wide = '0;
        alu_res  = acc;
        alu_c    = 1'b0;
        case (SelALU)
            ALU_ADD: begin
                alu_wide = {1'b0, acc} + {1'b0, rf_b};
                alu_res  = alu_wide[DW-1:0];
                alu_c    = alu_wide[DW];
            end
            ALU_SUB: begin
                // MSB of the widened difference is the unsigned borrow.
                alu_wide = {1'b0, acc} - {1'b0, rf_b};
                alu_res  = alu_wide[DW-1:0];
                alu_c    = alu_wide[DW];
            end
            ALU_NOR: alu_res = ~(acc | rf_b);
            ALU_SHL: begin
                alu_res = {acc[DW-2:0], 1'b0};
                alu_c   = acc[DW-1];
            end
            ALU_SHR: begin
                alu_res = {1'b0, acc[DW-1:1]};
                alu_c   = acc[0];
            end
            default: ;
        endcase
    end

    // PC and IR: jump beats increment, IR captures the word at the pre-edge PC.
    always_ff @(posedge clk) begin
        if (!CLB) begin
            pc <= '0;
            ir <= '0;
        end else begin
            if (LoadPC)      pc <= SelPC ? rel_tgt : reg_tgt;
            else if (IncPC)  pc <= pc + 1'b1;
            if (LoadIR)      ir <= imem_data;
        end
    end

    // Register file and ACC: a same-edge store and ACC load both see the old ACC.
    always_ff @(posedge clk) begin
        if (!CLB) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
            acc <= '0;
        end else begin
            if (LoadReg) rf[rs] <= acc;
            if (LoadAcc) begin
                case (SelACC)
                    ACC_ALU: acc <= alu_res;
                    ACC_REG: acc <= rf_b;
                    ACC_IMM: acc <= imm;
                    default: acc <= acc;
                endcase
            end
        end
    end

    // Flags follow the ALU only when the ALU result is what lands in ACC.
    always_ff @(posedge clk) begin
        if (!CLB) begin
            z_q <= 1'b0;
            c_q <= 1'b0;
        end else if (LoadAcc && SelACC == ACC_ALU) begin
            z_q <= (alu_res == '0);
            c_q <= alu_c;
        end
    end

`ifdef DATAPATH_DBG_EN
    // Debug tap: registered copy of the selected register, refreshed every edge.
    always_ff @(posedge clk) begin
        if (!CLB) dbg_reg <= '0;
        else      dbg_reg <= rf[dbg_sel];
    end
`endif

    assign imem_addr = pc;
    assign op        = ir[7:4];
    assign z         = z_q;
    assign c         = c_q;
    assign acc_out   = acc;

endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed scenarios plus randomized control words, scored against an arithmetic reference model.
// Latency: expectations are queued after each clock edge and checked by the monitor at the following falling edge.
// Backpressure: not applicable; one control word per cycle.
module tb_datapath;

    logic       clk = 1'b0;
    logic       CLB, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
    logic [1:0] SelACC;
    logic [3:0] SelALU;
    logic [7:0] imem_data;
    logic [7:0] imem_addr;
    logic [3:0] op;
    logic       z, c;
    logic [7:0] acc_out;
    logic [1:0] dbg_sel = 2'd0;
`ifdef DATAPATH_DBG_EN
    logic [7:0] dbg_reg;
`endif

    always #5 clk = ~clk;

    datapath #(.DW(8), .PC_W(8)) dut (
        .clk(clk), .CLB(CLB), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
        .LoadPC(LoadPC), .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelACC(SelACC),
        .SelALU(SelALU), .imem_data(imem_data), .imem_addr(imem_addr), .op(op),
        .z(z), .c(c),
`ifdef DATAPATH_DBG_EN
        .dbg_sel(dbg_sel), .dbg_reg(dbg_reg),
`endif
        .acc_out(acc_out)
    );

    typedef struct packed {
        logic       clb, li, ipc, spc, lpc, lreg, lacc;
        logic [1:0] sacc;
        logic [3:0] salu;
        logic [7:0] imd;
    } ctl_t;

    typedef struct { int pc; int op; int z; int c; int acc; int dbg; } exp_t;
    typedef struct { int fld; int val; string name; } dir_t;

    exp_t exp_q[$];
    dir_t dir_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state, plain integers.
    int m_pc = 0, m_ir = 0, m_acc = 0, m_z = 0, m_c = 0, m_dbg = 0;
    int m_r[4] = '{0, 0, 0, 0};

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: one model entry per cycle, plus any directed expectations queued for this cycle.
    exp_t e;
    dir_t d;
    int   act;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pc",  imem_addr, e.pc);
            chk("op",  op,        e.op);
            chk("z",   z,         e.z);
            chk("c",   c,         e.c);
            chk("acc", acc_out,   e.acc);
`ifdef DATAPATH_DBG_EN
            chk("dbg", dbg_reg,   e.dbg);
`endif
        end
        while (dir_q.size() > 0) begin
            d = dir_q.pop_front();
            case (d.fld)
                0: act = imem_addr;
                1: act = op;
                2: act = z;
                3: act = c;
                4: act = acc_out;
`ifdef DATAPATH_DBG_EN
                5: act = dbg_reg;
`endif
                default: act = -1;
            endcase
            chk(d.name, act, d.val);
        end
    end

    task automatic expect_next(input int fld, input int val, input string nm);
        dir_t t;
        t.fld = fld; t.val = val; t.name = nm;
        dir_q.push_back(t);
    endtask

    // Reference model: the spec's rules in integer arithmetic.
    task automatic model(input ctl_t k);
        int a, b, res, cy, rs, s, npc;
        rs = m_ir % 4;
        a  = m_acc;
        b  = m_r[rs];
        cy = 0;
        case (k.salu)
            4'd1:  begin res = a + b; cy = (res > 255) ? 1 : 0; res = res % 256; end
            4'd2:  begin cy = (a < b) ? 1 : 0; res = (a - b + 256) % 256; end
            4'd3:  res = 255 - (a | b);
            4'd11: begin res = (a * 2) % 256; cy = (a >= 128) ? 1 : 0; end
            4'd12: begin res = a / 2; cy = a % 2; end
            default: res = a;
        endcase
        if (!k.clb) begin
            m_pc = 0; m_ir = 0; m_acc = 0; m_z = 0; m_c = 0; m_dbg = 0;
            for (int i = 0; i < 4; i++) m_r[i] = 0;
            return;
        end
        m_dbg = m_r[dbg_sel];
        npc = m_pc;
        if (k.lpc) begin
            if (k.spc) begin
                s = m_ir % 16;
                if (s >= 8) s = s - 16;
                npc = (m_pc + s + 256) % 256;
            end else begin
                npc = b;
            end
        end else if (k.ipc) begin
            npc = (m_pc + 1) % 256;
        end
        m_pc = npc;
        if (k.lreg) m_r[rs] = a;
        if (k.lacc) begin
            case (k.sacc)
                2'd0: m_acc = res;
                2'd1: m_acc = b;
                2'd2: m_acc = m_ir % 16;
                default: m_acc = a;
            endcase
            if (k.sacc == 2'd0) begin
                m_z = (res == 0) ? 1 : 0;
                m_c = cy;
            end
        end
        if (k.li) m_ir = k.imd;
    endtask

    task automatic run(input ctl_t k);
        exp_t x;
        CLB = k.clb; LoadIR = k.li; IncPC = k.ipc; SelPC = k.spc; LoadPC = k.lpc;
        LoadReg = k.lreg; LoadAcc = k.lacc; SelACC = k.sacc; SelALU = k.salu;
        imem_data = k.imd;
        model(k);
        @(posedge clk);
        x.pc = m_pc; x.op = m_ir / 16; x.z = m_z; x.c = m_c; x.acc = m_acc; x.dbg = m_dbg;
        exp_q.push_back(x);
        @(negedge clk);
        #1;
    endtask

    function automatic ctl_t nop();
        ctl_t k = '0;
        k.clb = 1'b1;
        return k;
    endfunction

    function automatic ctl_t rnd();
        ctl_t k;
        k.clb  = 1'b1;
        k.li   = 1'($urandom_range(0, 1));
        k.ipc  = 1'($urandom_range(0, 1));
        k.spc  = 1'($urandom_range(0, 1));
        k.lpc  = ($urandom_range(0, 3) == 0);
        k.lreg = 1'($urandom_range(0, 1));
        k.lacc = 1'($urandom_range(0, 1));
        k.sacc = 2'($urandom_range(0, 3));
        k.salu = 4'($urandom_range(0, 15));
        k.imd  = 8'($urandom_range(0, 255));
        return k;
    endfunction

    task automatic ld_ir(input logic [7:0] v);
        ctl_t k = nop();
        k.li = 1'b1; k.imd = v;
        run(k);
    endtask

    task automatic ld_acc(input logic [1:0] sel, input logic [3:0] alu);
        ctl_t k = nop();
        k.lacc = 1'b1; k.sacc = sel; k.salu = alu;
        run(k);
    endtask

    task automatic st_reg();
        ctl_t k = nop();
        k.lreg = 1'b1;
        run(k);
    endtask

    task automatic jump(input logic rel, input logic inc);
        ctl_t k = nop();
        k.lpc = 1'b1; k.spc = rel; k.ipc = inc;
        run(k);
    endtask

    // ACC <= v using only imm, SHL and ADD; clobbers R[v[1:0]] and the flags.
    task automatic set_acc(input logic [7:0] v);
        ld_ir({4'h0, v[3:0]});
        ld_acc(2'd2, 4'h0);
        st_reg();
        ld_ir({4'h0, v[7:4]});
        ld_acc(2'd2, 4'h0);
        repeat (4) ld_acc(2'd0, 4'hB);
        ld_ir({4'h0, v[3:0]});
        ld_acc(2'd0, 4'h1);
    endtask

    task automatic set_reg(input logic [1:0] r, input logic [7:0] v);
        set_acc(v);
        ld_ir({6'h0, r});
        st_reg();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end

    initial begin
        ctl_t k;
        k = nop(); k.clb = 1'b0;
        run(k);

        // Reset after random activity, with loads asserted on the reset edge.
        repeat (20) run(rnd());
        k = rnd(); k.clb = 1'b0; k.li = 1'b1; k.lacc = 1'b1; k.lpc = 1'b1;
        expect_next(0, 0, "rst_pc");
        expect_next(1, 0, "rst_op");
        expect_next(4, 0, "rst_acc");
        expect_next(2, 0, "rst_z");
        expect_next(3, 0, "rst_c");
        run(k);
        for (int i = 0; i < 4; i++) begin
            ld_ir(8'(i));
            expect_next(4, 0, "rst_reg");
            ld_acc(2'd1, 4'h0);
        end

        // Fetch, then PC wrap at FF.
        k = nop(); k.clb = 1'b0;
        run(k);
        k = nop(); k.li = 1'b1; k.ipc = 1'b1; k.imd = 8'h1D;
        expect_next(1, 1, "fetch_op");
        expect_next(0, 1, "fetch_pc");
        run(k);
        set_reg(2'd3, 8'hFF);
        expect_next(0, 8'hFF, "jmp_ff");
        jump(1'b0, 1'b0);
        k = nop(); k.li = 1'b1; k.ipc = 1'b1; k.imd = 8'h5A;
        expect_next(0, 0, "pc_wrap");
        run(k);

        // ADD with carry out, SUB to zero.
        set_reg(2'd1, 8'h20);
        set_acc(8'hF0);
        ld_ir(8'h01);
        expect_next(4, 8'h10, "add_acc");
        expect_next(3, 1, "add_c");
        expect_next(2, 0, "add_z");
        ld_acc(2'd0, 4'h1);
        set_reg(2'd1, 8'h05);
        set_acc(8'h05);
        expect_next(4, 0, "sub_acc");
        expect_next(2, 1, "sub_z");
        expect_next(3, 0, "sub_c");
        ld_acc(2'd0, 4'h2);

        // Flags hold on an immediate load; SHR sets both flags.
        ld_ir(8'h07);
        expect_next(4, 7, "imm_acc");
        expect_next(2, 1, "hold_z");
        ld_acc(2'd2, 4'h0);
        ld_ir(8'h01);
        ld_acc(2'd2, 4'h0);
        expect_next(4, 0, "shr_acc");
        expect_next(3, 1, "shr_c");
        expect_next(2, 1, "shr_z");
        ld_acc(2'd0, 4'hC);

        // Relative jump backwards beats IncPC; register jump.
        set_reg(2'd3, 8'h10);
        expect_next(0, 8'h10, "jmp_10");
        jump(1'b0, 1'b0);
        ld_ir(8'h0E);
        expect_next(0, 8'h0E, "jmp_rel");
        jump(1'b1, 1'b1);
        set_reg(2'd2, 8'h33);
        ld_ir(8'h02);
        expect_next(0, 8'h33, "jmp_reg");
        jump(1'b0, 1'b0);

        // Same-edge store and ACC load: R0 gets the old ACC.
        dbg_sel = 2'd0;
        set_reg(2'd0, 8'h00);
        set_acc(8'hAA);
        ld_ir(8'h00);
        k = nop(); k.lreg = 1'b1; k.lacc = 1'b1; k.sacc = 2'd1;
        expect_next(4, 0, "wr_rd_acc");
        run(k);
`ifdef DATAPATH_DBG_EN
        expect_next(5, 8'hAA, "dbg_r0");
`endif
        expect_next(4, 8'hAA, "wr_rd_r0");
        ld_acc(2'd1, 4'h0);

        // Randomized control words with occasional resets.
        for (int n = 0; n < 600; n++) begin
            k = rnd();
            k.clb = ($urandom_range(0, 39) != 0);
            dbg_sel = 2'($urandom_range(0, 3));
            run(k);
        end

        chk("drain", exp_q.size() + dir_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
